// File: rtl/sin_frame_sequencer.sv
// Host serial frame sequencer: synchronises the host cs/clk/din pins into clk and
// steers each received bit to one shift register of a bank, then issues its latch.
module sin_frame_sequencer #(
    parameter int NREG = 4,
    parameter int SELW = 2,
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            r_cs_n,
    input  logic            r_clk,
    input  logic            r_din,
    input  logic [SELW-1:0] r_sel,
    input  logic            err_clr,
    output logic [NREG-1:0] sr_cs,
    output logic            sr_le,
    output logic            sr_din,
    output logic            busy,
    output logic            latched,
    output logic            err_short,
    output logic            err_over,
    output logic            err_sel
);
    localparam int CW = $clog2(BITS + 1);
    localparam logic [SELW:0] NREG_W = (SELW + 1)'(NREG);
    localparam logic [CW-1:0] CNT_LAST = CW'(BITS - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(BITS);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH, S_WAIT} state_t;

    logic            r_cs_s1, r_cs_s2;
    logic            r_ck_s1, r_ck_s2, r_ck_d;
    logic            r_dn_s1, r_dn_s2;
    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [SELW-1:0] r_selq, w_sel_nxt;
    logic [NREG-1:0] r_sr_cs, w_cs_nxt, w_onehot;
    logic            r_sr_le, w_le_nxt;
    logic            r_sr_din, w_din_nxt;
    logic            r_busy, r_latched, w_latch_nxt;
    logic            r_err_short, r_err_over, r_err_sel;
    logic            w_set_short, w_set_over, w_set_sel;
    logic            w_edge, w_sel_ok;

    // Two-flop synchronisers; cs_n idles high so its flops reset to 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_s1 <= 1'b1;
            r_cs_s2 <= 1'b1;
            r_ck_s1 <= 1'b0;
            r_ck_s2 <= 1'b0;
            r_ck_d  <= 1'b0;
            r_dn_s1 <= 1'b0;
            r_dn_s2 <= 1'b0;
        end else begin
            r_cs_s1 <= r_cs_n;
            r_cs_s2 <= r_cs_s1;
            r_ck_s1 <= r_clk;
            r_ck_s2 <= r_ck_s1;
            r_ck_d  <= r_ck_s2;
            r_dn_s1 <= r_din;
            r_dn_s2 <= r_dn_s1;
        end
    end

    assign w_edge   = r_ck_s2 & ~r_ck_d;
    assign w_sel_ok = {1'b0, r_sel} < NREG_W;

    always_comb begin
        w_onehot = '0;
        for (int k = 0; k < NREG; k++) w_onehot[k] = (r_selq == SELW'(k));
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_selq;
        w_cs_nxt    = '0;
        w_le_nxt    = 1'b0;
        w_din_nxt   = 1'b0;
        w_latch_nxt = 1'b0;
        w_set_short = 1'b0;
        w_set_over  = 1'b0;
        w_set_sel   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_cs_s2) begin
                    if (w_sel_ok) begin
                        w_sel_nxt   = r_sel;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_SHIFT;
                    end else begin
                        w_set_sel   = 1'b1;
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_SHIFT: begin
                // Frame end takes priority over an edge seen in the same cycle
                if (r_cs_s2) begin
                    w_set_short = (r_cnt != '0);
                    w_state_nxt = S_IDLE;
                end else if (w_edge) begin
                    w_cs_nxt  = w_onehot;
                    w_din_nxt = r_dn_s2;
                    if (r_cnt != CNT_FULL) w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) w_state_nxt = S_LATCH;
                end
            end
            S_LATCH: begin
                w_cs_nxt    = w_onehot;
                w_le_nxt    = 1'b1;
                w_latch_nxt = 1'b1;
                w_set_over  = w_edge;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_cs_s2) w_state_nxt = S_IDLE;
                else         w_set_over  = w_edge;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bank-facing strobes are registered so the shifters see glitch-free pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_selq      <= '0;
            r_sr_cs     <= '0;
            r_sr_le     <= 1'b0;
            r_sr_din    <= 1'b0;
            r_busy      <= 1'b0;
            r_latched   <= 1'b0;
            r_err_short <= 1'b0;
            r_err_over  <= 1'b0;
            r_err_sel   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_selq      <= w_sel_nxt;
            r_sr_cs     <= w_cs_nxt;
            r_sr_le     <= w_le_nxt;
            r_sr_din    <= w_din_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_latched   <= w_latch_nxt;
            r_err_short <= w_set_short | (r_err_short & ~err_clr);
            r_err_over  <= w_set_over  | (r_err_over  & ~err_clr);
            r_err_sel   <= w_set_sel   | (r_err_sel   & ~err_clr);
        end
    end

    assign sr_cs     = r_sr_cs;
    assign sr_le     = r_sr_le;
    assign sr_din    = r_sr_din;
    assign busy      = r_busy;
    assign latched   = r_latched;
    assign err_short = r_err_short;
    assign err_over  = r_err_over;
    assign err_sel   = r_err_sel;

endmodule

// File: tb/tb_sin_frame_sequencer.sv
// Scoreboard bench for sin_frame_sequencer: host-side frames in, bank strobes and
// an attached model shifter bank checked against queued expectations.
module tb_sin_frame_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       r_cs_n = 1'b1, r_cs3_n = 1'b1;
    logic       r_clk = 1'b0, r_din = 1'b0, err_clr = 1'b0;
    logic [1:0] r_sel = 2'd0;
    logic [3:0] sr_cs;
    logic       sr_le, sr_din, busy, latched, err_short, err_over, err_sel;
    logic [2:0] sr_cs3;
    logic       sr_le3, sr_din3, busy3, latched3, err_short3, err_over3, err_sel3;

    always #5 clk = ~clk;

    sin_frame_sequencer #(.NREG(4), .SELW(2), .BITS(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .r_cs_n(r_cs_n), .r_clk(r_clk), .r_din(r_din),
        .r_sel(r_sel), .err_clr(err_clr), .sr_cs(sr_cs), .sr_le(sr_le),
        .sr_din(sr_din), .busy(busy), .latched(latched), .err_short(err_short),
        .err_over(err_over), .err_sel(err_sel));

    sin_frame_sequencer #(.NREG(3), .SELW(2), .BITS(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .r_cs_n(r_cs3_n), .r_clk(r_clk), .r_din(r_din),
        .r_sel(r_sel), .err_clr(err_clr), .sr_cs(sr_cs3), .sr_le(sr_le3),
        .sr_din(sr_din3), .busy(busy3), .latched(latched3), .err_short(err_short3),
        .err_over(err_over3), .err_sel(err_sel3));

    typedef struct packed {
        logic [1:0] sel;
        logic       din;
        logic       le;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0, n_err = 0, n_lat = 0;
    logic [7:0] sh[4];
    logic [7:0] dout[4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Model of the attached 8-bit SIPO bank, MSB first
    initial for (int k = 0; k < 4; k++) begin sh[k] = 8'h00; dout[k] = 8'h00; end
    always @(posedge clk)
        for (int k = 0; k < 4; k++)
            if (sr_cs[k]) begin
                if (sr_le) dout[k] <= sh[k];
                else       sh[k]   <= {sh[k][6:0], sr_din};
            end

    always @(negedge clk) begin
        exp_t e;
        if (latched) n_lat++;
        if ((sr_le || latched) && sr_cs == 4'd0) chk("le_without_cs", {sr_le, latched}, 0);
        if (sr_cs3 != 3'd0) chk("dut3_cs", 32'(sr_cs3), 0);
        if (sr_cs != 4'd0) begin
            if (q.size() == 0) chk("unexpected_cs", 32'(sr_cs), 0);
            else begin
                e = q.pop_front();
                chk("cs", 32'(sr_cs), 32'(4'd1 << e.sel));
                chk("le", 32'(sr_le), 32'(e.le));
                chk("latched", 32'(latched), 32'(e.le));
                if (!e.le) chk("din", 32'(sr_din), 32'(e.din));
            end
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input bit push_shift, input bit push_latch);
        r_din = b;
        wait_n(3);
        if (push_shift) q.push_back('{sel: r_sel, din: b, le: 1'b0});
        if (push_latch) q.push_back('{sel: r_sel, din: 1'b0, le: 1'b1});
        r_clk = 1'b1;
        wait_n(4);
        r_clk = 1'b0;
        wait_n(4);
    endtask

    task automatic start(input logic [1:0] sel);
        r_sel  = sel;
        r_cs_n = 1'b0;
        wait_n(4);
    endtask

    task automatic stop();
        r_cs_n = 1'b1;
        wait_n(6);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        wait_n(1);
        err_clr = 1'b0;
        wait_n(1);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[7-i], 1'b1, i == 7);
    endtask

    initial begin
        logic [7:0] pat;
        wait_n(3);
        chk("rst_outs", {sr_cs, sr_le, sr_din, busy, latched, err_short, err_over, err_sel}, 0);
        rst_n = 1'b1;
        wait_n(3);
        chk("idle_busy", 32'(busy), 0);

        // Full byte A5 to register 2
        start(2'd2);
        chk("t1_busy", 32'(busy), 1);
        send_byte(8'hA5);
        wait_n(3);
        chk("t1_dout", 32'(dout[2]), 32'hA5);
        stop();
        chk("t1_errs", {err_short, err_over, err_sel}, 0);
        chk("t1_busy_end", 32'(busy), 0);

        // Short frame: 5 edges then end
        start(2'd1);
        for (int i = 0; i < 5; i++) send_bit(i[0], 1'b1, 1'b0);
        stop();
        chk("t2_short", 32'(err_short), 1);
        chk("t2_busy", 32'(busy), 0);
        pulse_clr();
        chk("t2_clr", 32'(err_short), 0);

        // Overlong frame: 10 edges to register 0, first 8 carry 5A
        pat = 8'h5A;
        start(2'd0);
        for (int i = 0; i < 10; i++)
            send_bit(i < 8 ? pat[7-i] : 1'b1, i < 8, i == 7);
        chk("t3_over", 32'(err_over), 1);
        chk("t3_dout", 32'(dout[0]), 32'h5A);
        stop();
        chk("t3_short", 32'(err_short), 0);

        // Reset after 4 edges, then a fresh 3C frame to register 1
        start(2'd1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1, 1'b0);
        rst_n  = 1'b0;
        r_cs_n = 1'b1;
        wait_n(2);
        chk("t5_rst_outs", {sr_cs, sr_le, sr_din, busy, latched, err_short, err_over, err_sel}, 0);
        chk("t5_no_latch", 32'(dout[1]), 0);
        rst_n = 1'b1;
        wait_n(3);
        start(2'd1);
        send_byte(8'h3C);
        wait_n(3);
        chk("t5_dout", 32'(dout[1]), 32'h3C);
        stop();

        // cs_n rise together with 8th edge: edge dropped, short frame
        start(2'd3);
        for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b1, 1'b0);
        r_din = 1'b0;
        wait_n(3);
        r_clk  = 1'b1;
        r_cs_n = 1'b1;
        wait_n(4);
        r_clk = 1'b0;
        wait_n(6);
        chk("t6_short", 32'(err_short), 1);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_dout", 32'(dout[3]), 0);
        pulse_clr();

        // NREG=3 instance with out-of-range select
        r_sel   = 2'd3;
        r_cs3_n = 1'b0;
        wait_n(4);
        for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0, 1'b0);
        chk("t4_busy", 32'(busy3), 1);
        chk("t4_err_sel", 32'(err_sel3), 1);
        chk("t4_latched", 32'(latched3), 0);
        r_cs3_n = 1'b1;
        wait_n(6);
        chk("t4_busy_end", 32'(busy3), 0);
        chk("t4_main_idle", {busy, err_sel}, 0);

        chk("queue_empty", 32'(q.size()), 0);
        chk("latch_count", 32'(n_lat), 3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
